// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between a UART rx/tx pair and a combinational ALU.
// Collects A, B and opcode bytes, runs the ALU, then transmits the result.
module uart_alu_ctrl #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBIT-1:0]  rx_data,
    input  logic             rx_ready,
    input  logic             tx_done,
    input  logic [DBIT-1:0]  alu_result,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    output logic [DBIT-1:0]  tx_data,
    output logic             tx_start,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          expire;
    logic          unused_hi;

    // Only the low NB_OP bits of the opcode byte carry meaning.
    assign unused_hi = ^rx_data[DBIT-1:NB_OP];

    assign expire = (TIMEOUT != 0) && (cnt == LAST);
    assign busy   = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_A;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            cnt         <= '0;
            case (state)
                WAIT_A: begin
                    if (rx_ready) begin
                        alu_a <= rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte in the expiry cycle still wins over the timeout.
                    if (rx_ready) begin
                        alu_b <= rx_data;
                        state <= WAIT_OP;
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= WAIT_A;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (rx_ready) begin
                        alu_op <= rx_data[NB_OP-1:0];
                        state  <= EXEC;
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= WAIT_A;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXEC: begin
                    // Capture here so tx_start and tx_data are registered for the SEND cycle.
                    err_overrun <= rx_ready;
                    tx_data     <= alu_result;
                    tx_start    <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    err_overrun <= rx_ready;
                    state       <= WAIT_TX;
                end
                WAIT_TX: begin
                    err_overrun <= rx_ready;
                    if (tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule
